// File: rtl/aes_pkg.sv
// Shared AES-128 constants, tables, GF(2^8) helpers and the single-round datapath.
package aes_pkg;

  localparam int unsigned NR    = 10;
  localparam int unsigned BLK_W = 128;
  localparam int unsigned NW    = 4 * (NR + 1);

  typedef logic [BLK_W-1:0] round_keys_t [0:NR];

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } aes_state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One cipher round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
  // Byte i sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [BLK_W-1:0] aes_round(input logic [BLK_W-1:0] s,
                                                 input logic [BLK_W-1:0] rk,
                                                 input logic             last);
    logic [7:0]       sb [0:15];
    logic [7:0]       sr [0:15];
    logic [7:0]       a0, a1, a2, a3;
    logic [BLK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        sr[4*c+rw] = sb[4*((c+rw)%4)+rw];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
        sr[4*c]   = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        sr[4*c+1] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        sr[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        sr[4*c+3] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sr[i];
    return r ^ rk;
  endfunction

endpackage

// File: rtl/aes_key_expand.sv
// Combinational AES-128 key expansion into eleven round keys.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] key_i,
  output round_keys_t      k_sch
);

  // Word-serial KeyExpansion; w is block-local so the loop has no feedback net.
  always_comb begin
    logic [31:0] w [0:NW-1];
    logic [31:0] tmp;
    tmp = '0;
    for (int unsigned i = 0; i < NW; i++) w[i] = '0;
    for (int unsigned i = 0; i < 4; i++) w[i] = key_i[127-32*i -: 32];
    for (int unsigned i = 4; i < NW; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {RCON[i/4], 24'h000000};
      w[i] = w[i-4] ^ tmp;
    end
    for (int unsigned r = 0; r <= NR; r++) k_sch[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryptor: one round per clock, 10-cycle start-to-result latency.
module aes_encrypt
  import aes_pkg::*;
#(
  parameter int unsigned NK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [32*NK-1:0]  key,
  input  logic              load,
  input  logic [BLK_W-1:0]  pt,
  output logic [BLK_W-1:0]  ct,
  output logic              valid,
  output round_keys_t       k_sch
);

  localparam int unsigned RND_W = 4;

  if (NK != 4) begin : g_nk_check
    $error("aes_encrypt: only NK=4 (AES-128) is supported");
  end

  aes_state_e       state_q, state_d;
  logic [BLK_W-1:0] st_q, st_d;
  logic [BLK_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] ct_q, ct_d;
  logic [RND_W-1:0] round_q, round_d;
  logic             valid_q, valid_d;
  logic             load_q, load_d;
  logic             start_c;
  logic [BLK_W-1:0] rnd_c;

  aes_key_expand u_key_expand (
    .key_i (key_q),
    .k_sch (k_sch)
  );

  assign start_c = load & ~load_q;
  assign rnd_c   = aes_round(st_q, k_sch[round_q], round_q == RND_W'(NR));

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      st_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      round_q <= round_d;
      valid_q <= valid_d;
      load_q  <= load_d;
    end
  end

  // Next-state: key tracks input while idle, frozen while a run is in flight.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    ct_d    = ct_q;
    round_d = round_q;
    valid_d = valid_q;
    load_d  = load;
    unique case (state_q)
      ST_IDLE: begin
        key_d = BLK_W'(key);
        if (start_c) begin
          st_d    = pt ^ BLK_W'(key);
          round_d = RND_W'(1);
          valid_d = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        st_d = rnd_c;
        if (round_q == RND_W'(NR)) begin
          ct_d    = rnd_c;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          round_d = round_q + RND_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ct    = ct_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_aes_encrypt.sv
// Directed bench for aes_encrypt: known-answer vectors plus multi-cycle corner cases.
module tb_aes_encrypt;
  import aes_pkg::*;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [127:0] key;
  logic [127:0] pt;
  logic [127:0] ct;
  logic         valid;
  round_keys_t  k_sch;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  aes_encrypt #(.NK(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .key   (key),
    .load  (load),
    .pt    (pt),
    .ct    (ct),
    .valid (valid),
    .k_sch (k_sch)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse load for one edge, then wait (bounded) for valid and check latency and ct.
  task automatic run_vec(input vec_t v, input string name);
    int lat;
    key  = v.key;
    pt   = v.pt;
    load = 1'b1;
    tick();
    load = 1'b0;
    check({name, " valid clears on start"}, 128'(valid), 128'(0));
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!valid && lat < 20);
    check({name, " latency"}, 128'(lat), 128'(10));
    check({name, " ct"}, ct, v.ct);
  endtask

  initial begin
    vec_t vecs [3];
    int   rises;
    int   drops;
    int   cnt;
    logic prev;

    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                pt:  128'h00112233445566778899aabbccddeeff,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt:  128'h3243f6a8885a308d313198a2e0370734,
                ct:  128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{key: 128'h0,
                pt:  128'h0,
                ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    // Reset values
    rst = 1'b1; load = 1'b0; key = '0; pt = '0;
    tick(); tick();
    check("reset valid", 128'(valid), 128'(0));
    check("reset ct", ct, 128'h0);
    check("reset k_sch0", k_sch[0], 128'h0);
    check("reset k_sch1", k_sch[1], 128'h62636363626363636263636362636363);

    // Idle key tracking and expansion
    rst = 1'b0;
    key = vecs[1].key;
    tick();
    check("idle k_sch0", k_sch[0], vecs[1].key);
    check("idle k_sch1", k_sch[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("idle k_sch10", k_sch[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Known-answer vectors, back to back (each start follows a valid=1)
    for (int i = 0; i < 3; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Held load produces exactly one encryption
    key = vecs[0].key; pt = vecs[0].pt;
    load = 1'b1;
    rises = 0;
    prev = valid;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (valid && !prev) rises++;
      prev = valid;
    end
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (valid && !prev) rises++;
      prev = valid;
    end
    check("held load rises", 128'(rises), 128'(1));
    check("held load valid", 128'(valid), 128'(1));
    check("held load ct", ct, vecs[0].ct);

    // Inputs change mid-run and a second load edge arrives while busy
    key = vecs[0].key; pt = vecs[0].pt;
    load = 1'b1;
    tick();
    load = 1'b0;
    cnt = 0;
    tick(); tick(); cnt += 2;
    key = vecs[1].key; pt = vecs[1].pt;
    tick(); tick(); cnt += 2;
    load = 1'b1;
    tick(); cnt++;
    load = 1'b0;
    while (!valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check("midrun latency", 128'(cnt), 128'(10));
    check("midrun ct", ct, vecs[0].ct);
    drops = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!valid) drops++;
    end
    check("midrun no retrigger", 128'(drops), 128'(0));
    check("midrun ct hold", ct, vecs[0].ct);
    check("midrun key follows", k_sch[0], vecs[1].key);

    // Reset during BUSY aborts the run
    key = vecs[1].key; pt = vecs[1].pt;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    check("abort valid", 128'(valid), 128'(0));
    check("abort ct", ct, 128'h0);
    check("abort k_sch0", k_sch[0], 128'h0);
    rst = 1'b0;
    rises = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (valid) rises++;
    end
    check("abort no valid", 128'(rises), 128'(0));

    // Recovery after abort
    run_vec(vecs[1], "post-reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/aes_encrypt.md
AES_ENCRYPT -- requirements
Module: aes_encrypt

Interface
REQ-001 SHALL have parameter NK, default 4, meaning key length in 32-bit words; only NK=4 (AES-128, Nr=10) is supported, other values are an elaboration error.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port key, input, 32*NK bits: cipher key; key[127:120] is byte 0 (FIPS-197 order).
REQ-005 SHALL have port load, input, 1 bit: level request; each rising edge starts one encryption.
REQ-006 SHALL have port pt, input, 128 bits: plaintext; pt[127:120] is state byte 0.
REQ-007 SHALL have port ct, output, 128 bits: ciphertext, same byte order as pt.
REQ-008 SHALL have port valid, output, 1 bit: ct holds the result of the last completed encryption.
REQ-009 SHALL have port k_sch, output, unpacked array [0:10] of 128 bits: round keys 0..10 expanded from the internal key register; k_sch[0] equals the key.

Function
REQ-010 SHALL register load every cycle and detect start as load=1 with previous load=0; a level held high SHALL NOT retrigger.
REQ-011 SHALL have two states, IDLE and BUSY; start in IDLE SHALL go to BUSY; start in BUSY SHALL be ignored.
REQ-012 In IDLE, the key register SHALL copy key every cycle, so k_sch follows key with one cycle of latency.
REQ-013 In BUSY, the key register SHALL be frozen; changes on key SHALL NOT affect the run in progress.
REQ-014 On start, the state register SHALL load pt XOR key.
REQ-015 On start, the key register SHALL load key.
REQ-016 On start, the round counter SHALL be set to 1.
REQ-017 On start, valid SHALL clear to 0.
REQ-018 In BUSY, each cycle SHALL apply one round with k_sch[round]: SubBytes, ShiftRows, MixColumns, AddRoundKey.
REQ-019 Round 10 SHALL omit MixColumns.
REQ-020 After round 10, the counter SHALL stop.
REQ-021 After round 10, ct SHALL be written with the result.
REQ-022 After round 10, valid SHALL be set to 1.
REQ-023 After round 10, the state machine SHALL return to IDLE.
REQ-024 Latency SHALL be fixed: if start is detected at edge N, then ct and valid update at edge N+10.
REQ-025 ct and valid SHALL hold until the next start or reset.
REQ-026 Key expansion SHALL use FIPS-197 KeyExpansion with RotWord, SubWord and Rcon = 01,02,04,08,10,20,40,80,1b,36.
REQ-027 Key expansion SHALL be combinational from the key register.
REQ-028 All GF(2^8) arithmetic SHALL use xtime with the polynomial 0x11b; all widths are exact, with no truncation.

Reset
REQ-029 On rst=1 at a clock edge, the state machine SHALL go to IDLE.
REQ-030 On reset, valid SHALL be 0.
REQ-031 On reset, ct SHALL be 0.
REQ-032 On reset, the state register SHALL be 0.
REQ-033 On reset, the round counter SHALL be 0.
REQ-034 On reset, the registered copy of load SHALL be 0.
REQ-035 On reset, the key register SHALL be 0, so k_sch[0]=0 and k_sch[1]=62636363626363636263636362636363.
REQ-036 rst SHALL take priority over start.
REQ-037 Reset during BUSY SHALL abort the run; the aborted result SHALL NOT appear.

Structure
REQ-038 Package aes_pkg SHALL hold constant NR=10, the S-box table or function, the Rcon table, the xtime function, and a typedef for the round-key array.
REQ-039 Sub-module aes_key_expand SHALL map a 128-bit key to k_sch[0:10]; aes_encrypt SHALL instantiate it once.
REQ-040 Input debouncing (chattering_remover) SHALL stay outside this block and is specified separately.

Verification
REQ-041 key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff, load pulse -> 10 cycles later valid=1, ct=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-042 key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734 -> ct=3925841d02dc09fbdc118597196a0b32; k_sch[1]=a0fafe1788542cb123a339392a6c7605; k_sch[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-043 Hold load high for 30 cycles -> exactly one encryption; valid rises once and stays 1.
REQ-044 Change key and pt at cycle 3 of BUSY, and raise a second load edge at cycle 5 -> ct unchanged from the original vector; the second edge is ignored.
REQ-045 Assert rst at cycle 6 of BUSY -> valid=0, ct=0 and k_sch[0]=0 after the edge; no valid rise follows.
REQ-046 After valid=1, a new load edge -> valid=0 the next cycle, then 1 again with the new ct after 10 cycles.
